onchip_ram_dp: RTL and testbench

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slaves, s1 and s2, for Nios II instruction/data memory and custom-IP buffers.

---
 rtl/onchip_ram_pkg.sv | 17 +
 rtl/onchip_ram_rd_pipe.sv | 40 ++++
 rtl/onchip_ram_dp.sv | 165 ++++++++++++++++
 tb/tb_onchip_ram_dp.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and constants for the dual-port on-chip RAM.
// Lane-count helper and legal read-latency bounds live here.
package onchip_ram_pkg;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  function automatic int lane_count(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/onchip_ram_rd_pipe.sv
// Per-port readdata/readdatavalid shift pipeline.
// The whole pipe freezes while the enable is low.
module onchip_ram_rd_pipe
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid
);

  logic [DATA_WIDTH-1:0]   data_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign readdata      = data_q[READ_LATENCY-1];
  assign readdatavalid = valid_q[READ_LATENCY-1];

endmodule

// File: rtl/onchip_ram_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slaves.
// Holds the array, lane merge, collision rules and zero-fill FSM.
module onchip_ram_dp
  import onchip_ram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 14,
  parameter int DEPTH        = 10240,
  parameter int READ_LATENCY = 1,
  parameter int INIT_ZERO    = 1,
  parameter int RDW_NEW_DATA = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int NB = lane_count(DATA_WIDTH);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8) begin : g_bad_width
    $error("onchip_ram_dp: DATA_WIDTH must be a multiple of 8");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_WIDTH)) begin : g_bad_depth
    $error("onchip_ram_dp: DEPTH must fit in ADDR_WIDTH");
  end
  if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX)
  begin : g_bad_lat
    $error("onchip_ram_dp: READ_LATENCY must be 1 or 2");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] fill_q, fill_d;
  logic          fill_we;
  logic          en, busy;

  assign en             = clken & ~reset_req;
  assign busy           = (state_q == ST_INIT);
  assign s1_waitrequest = busy | ~en;
  assign s2_waitrequest = busy | ~en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (INIT_ZERO != 0) ? ST_INIT : ST_READY;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    fill_we = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        if (en) begin
          fill_we = 1'b1;
          fill_d  = fill_q + 1'b1;
          if (fill_q == LAST) state_d = ST_READY;
        end
      end
      ST_READY: ;
      default: state_d = ST_READY;
    endcase
  end

  // A port asserting read and write together only writes.
  logic acc1, acc2, in1, in2, w1, w2, r1, r2;
  logic [IW-1:0] idx1, idx2;

  assign acc1 = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;
  assign acc2 = s2_chipselect & (s2_read | s2_write) & ~s2_waitrequest;
  assign in1  = {1'b0, s1_address} < (ADDR_WIDTH+1)'(DEPTH);
  assign in2  = {1'b0, s2_address} < (ADDR_WIDTH+1)'(DEPTH);
  assign idx1 = s1_address[IW-1:0];
  assign idx2 = s2_address[IW-1:0];
  assign w1   = acc1 & s1_write & in1;
  assign w2   = acc2 & s2_write & in2;
  assign r1   = acc1 & s1_read & ~s1_write;
  assign r2   = acc2 & s2_read & ~s2_write;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // s1 lanes are written last so they win on a shared address.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_q] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (w2 && s2_byteenable[i])
          mem[idx2][i*8 +: 8] <= s2_writedata[i*8 +: 8];
      end
      for (int i = 0; i < NB; i++) begin
        if (w1 && s1_byteenable[i])
          mem[idx1][i*8 +: 8] <= s1_writedata[i*8 +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] old1, old2, new1, new2, rd1, rd2;

  always_comb begin
    old1 = in1 ? mem[idx1] : '0;
    old2 = in2 ? mem[idx2] : '0;
    new1 = old1;
    new2 = old2;
    for (int i = 0; i < NB; i++) begin
      if (in1 && w2 && idx2 == idx1 && s2_byteenable[i])
        new1[i*8 +: 8] = s2_writedata[i*8 +: 8];
      if (in2 && w1 && idx1 == idx2 && s1_byteenable[i])
        new2[i*8 +: 8] = s1_writedata[i*8 +: 8];
    end
    rd1 = (RDW_NEW_DATA != 0) ? new1 : old1;
    rd2 = (RDW_NEW_DATA != 0) ? new2 : old2;
  end

  onchip_ram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe1 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in_valid     (r1),
    .in_data      (rd1),
    .readdata     (s1_readdata),
    .readdatavalid(s1_readdatavalid)
  );

  onchip_ram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe2 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .in_valid     (r2),
    .in_data      (rd2),
    .readdata     (s2_readdata),
    .readdatavalid(s2_readdatavalid)
  );

endmodule

// File: tb/tb_onchip_ram_dp.sv
// Bench for onchip_ram_dp: two instances share stimulus,
// A with latency 1 / old-data RDW, B with latency 2 / new-data RDW.
module tb_onchip_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, clken, reset_req;
  logic [4:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] a1_rd, a2_rd, b1_rd, b2_rd;
  logic        a1_v, a2_v, b1_v, b2_v;
  logic        a1_w, a2_w, b1_w, b2_w;

  int passed = 0;
  int total  = 0;

  onchip_ram_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(1), .INIT_ZERO(1), .RDW_NEW_DATA(0)
  ) u_a (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(a1_rd), .s1_readdatavalid(a1_v),
    .s1_waitrequest(a1_w),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(a2_rd), .s2_readdatavalid(a2_v),
    .s2_waitrequest(a2_w)
  );

  onchip_ram_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(2), .INIT_ZERO(1), .RDW_NEW_DATA(1)
  ) u_b (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(b1_rd), .s1_readdatavalid(b1_v),
    .s1_waitrequest(b1_w),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(b2_rd), .s2_readdatavalid(b2_v),
    .s2_waitrequest(b2_w)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic drive(input int p, input logic rd, input logic wr,
                       input logic [4:0] a, input logic [31:0] d,
                       input logic [3:0] be);
    if (p == 1) begin
      s1_chipselect = 1; s1_read = rd; s1_write = wr;
      s1_address = a; s1_writedata = d; s1_byteenable = be;
    end else begin
      s2_chipselect = 1; s2_read = rd; s2_write = wr;
      s2_address = a; s2_writedata = d; s2_byteenable = be;
    end
  endtask

  task automatic wr(input int p, input logic [4:0] a,
                    input logic [31:0] d, input logic [3:0] be);
    drive(p, 1'b0, 1'b1, a, d, be);
    step;
    idle;
  endtask

  // av/ad sampled one cycle after accept, bv/bd two cycles after.
  task automatic rd_both(input int p, input logic [4:0] a,
                         output logic [31:0] ad, output logic av,
                         output logic [31:0] bd, output logic bv,
                         output logic bv_early);
    drive(p, 1'b1, 1'b0, a, 32'h0, 4'h0);
    step;
    idle;
    ad = (p == 1) ? a1_rd : a2_rd;
    av = (p == 1) ? a1_v : a2_v;
    bv_early = (p == 1) ? b1_v : b2_v;
    step;
    bd = (p == 1) ? b1_rd : b2_rd;
    bv = (p == 1) ? b1_v : b2_v;
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    while (a1_w && n < 64) begin
      step;
      n++;
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1; clken = 1; reset_req = 0; idle;
    s1_address = 0; s2_address = 0;
    s1_writedata = 0; s2_writedata = 0;
    s1_byteenable = 0; s2_byteenable = 0;
    step;
    step;
    total++;
    if (a1_w !== 1'b1) $display("FAIL reset_wait: got %b want 1", a1_w);
    else passed++;
    total++;
    if (b2_v !== 1'b0 || a1_v !== 1'b0)
      $display("FAIL reset_valid: got %b/%b want 0/0", a1_v, b2_v);
    else passed++;
    total++;
    if (a1_rd !== 32'h0 || b2_rd !== 32'h0)
      $display("FAIL reset_data: got %h/%h want 0/0", a1_rd, b2_rd);
    else passed++;
    reset = 0;
    wait_fill(n);
    total++;
    if (n !== 16) $display("FAIL init_len: got %0d want 16", n);
    else passed++;
    total++;
    if (b1_w !== 1'b0 || a2_w !== 1'b0)
      $display("FAIL init_done: got %b/%b want 0/0", b1_w, a2_w);
    else passed++;
  endtask

  task automatic test_init_read;
    logic [31:0] ad, bd;
    logic av, bv, be;
    rd_both(2, 5'd5, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'h0 || av !== 1'b1)
      $display("FAIL init_read_a: got %h v%b want 0 v1", ad, av);
    else passed++;
    total++;
    if (bd !== 32'h0 || bv !== 1'b1 || be !== 1'b0)
      $display("FAIL init_read_b: got %h v%b e%b want 0 v1 e0",
               bd, bv, be);
    else passed++;
  endtask

  task automatic test_byte_lanes;
    logic [31:0] ad, bd;
    logic av, bv, be;
    wr(1, 5'd3, 32'hAABBCCDD, 4'hF);
    wr(1, 5'd3, 32'h11223344, 4'h5);
    rd_both(2, 5'd3, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'hAA22CC44 || av !== 1'b1)
      $display("FAIL lanes_a: got %h v%b want aa22cc44 v1", ad, av);
    else passed++;
    total++;
    if (be !== 1'b0)
      $display("FAIL lanes_b_early: got %b want 0", be);
    else passed++;
    total++;
    if (bd !== 32'hAA22CC44 || bv !== 1'b1)
      $display("FAIL lanes_b: got %h v%b want aa22cc44 v1", bd, bv);
    else passed++;
  endtask

  task automatic test_write_collision;
    logic [31:0] ad, bd;
    logic av, bv, be;
    drive(1, 1'b0, 1'b1, 5'd7, 32'h000000FF, 4'h1);
    drive(2, 1'b0, 1'b1, 5'd7, 32'h0000EEEE, 4'h3);
    step;
    idle;
    rd_both(1, 5'd7, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'h0000EEFF || av !== 1'b1)
      $display("FAIL collide_a: got %h v%b want 0000eeff v1", ad, av);
    else passed++;
    total++;
    if (bd !== 32'h0000EEFF || bv !== 1'b1)
      $display("FAIL collide_b: got %h v%b want 0000eeff v1", bd, bv);
    else passed++;
  endtask

  task automatic test_rdw;
    logic [31:0] ad, bd;
    logic av, bv, be;
    wr(1, 5'd9, 32'h12345678, 4'hF);
    drive(1, 1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 4'hF);
    drive(2, 1'b1, 1'b0, 5'd9, 32'h0, 4'h0);
    step;
    idle;
    total++;
    if (a2_rd !== 32'h12345678 || a2_v !== 1'b1)
      $display("FAIL rdw_old: got %h v%b want 12345678 v1", a2_rd, a2_v);
    else passed++;
    step;
    total++;
    if (b2_rd !== 32'hCAFEF00D || b2_v !== 1'b1)
      $display("FAIL rdw_new: got %h v%b want cafef00d v1", b2_rd, b2_v);
    else passed++;
    rd_both(1, 5'd9, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'hCAFEF00D || bd !== 32'hCAFEF00D)
      $display("FAIL rdw_after: got %h/%h want cafef00d", ad, bd);
    else passed++;
  endtask

  task automatic test_back_to_back;
    drive(1, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    step;
    total++;
    if (a1_rd !== 32'hAA22CC44 || a1_v !== 1'b1)
      $display("FAIL b2b_a0: got %h v%b want aa22cc44 v1", a1_rd, a1_v);
    else passed++;
    drive(1, 1'b1, 1'b0, 5'd9, 32'h0, 4'h0);
    step;
    idle;
    total++;
    if (a1_rd !== 32'hCAFEF00D || a1_v !== 1'b1)
      $display("FAIL b2b_a1: got %h v%b want cafef00d v1", a1_rd, a1_v);
    else passed++;
    total++;
    if (b1_rd !== 32'hAA22CC44 || b1_v !== 1'b1)
      $display("FAIL b2b_b0: got %h v%b want aa22cc44 v1", b1_rd, b1_v);
    else passed++;
    step;
    total++;
    if (b1_rd !== 32'hCAFEF00D || b1_v !== 1'b1 || a1_v !== 1'b0)
      $display("FAIL b2b_b1: got %h v%b a%b want cafef00d v1 a0",
               b1_rd, b1_v, a1_v);
    else passed++;
  endtask

  task automatic test_enable_stall(input int use_rr);
    int bad;
    drive(2, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    step;
    idle;
    if (use_rr != 0) reset_req = 1;
    else clken = 0;
    #1;
    total++;
    if (b2_w !== 1'b1 || a2_w !== 1'b1)
      $display("FAIL stall_wait%0d: got %b/%b want 1/1", use_rr, a2_w, b2_w);
    else passed++;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      step;
      if (b2_v !== 1'b0 || a2_v !== 1'b1) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL stall_hold%0d: got %0d bad cycles want 0", use_rr, bad);
    else passed++;
    reset_req = 0;
    clken = 1;
    step;
    total++;
    if (b2_v !== 1'b1 || b2_rd !== 32'hAA22CC44 || a2_v !== 1'b0)
      $display("FAIL stall_deliver%0d: got %h v%b a%b want aa22cc44 v1 a0",
               use_rr, b2_rd, b2_v, a2_v);
    else passed++;
    step;
    total++;
    if (b2_v !== 1'b0)
      $display("FAIL stall_once%0d: got %b want 0", use_rr, b2_v);
    else passed++;
  endtask

  task automatic test_out_of_range;
    logic [31:0] ad, bd;
    logic av, bv, be;
    wr(1, 5'd16, 32'hDEADBEEF, 4'hF);
    rd_both(2, 5'd0, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'h0 || bd !== 32'h0)
      $display("FAIL oor_alias: got %h/%h want 0/0", ad, bd);
    else passed++;
    rd_both(2, 5'd16, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'h0 || av !== 1'b1 || bd !== 32'h0 || bv !== 1'b1)
      $display("FAIL oor_read: got %h v%b %h v%b want 0 v1 0 v1",
               ad, av, bd, bv);
    else passed++;
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] ad, bd;
    logic av, bv, be;
    int n;
    drive(2, 1'b1, 1'b0, 5'd3, 32'h0, 4'h0);
    step;
    idle;
    reset = 1;
    #1;
    total++;
    if (b2_v !== 1'b0 || a2_v !== 1'b0)
      $display("FAIL midrd_clear: got %b/%b want 0/0", a2_v, b2_v);
    else passed++;
    step;
    total++;
    if (b2_v !== 1'b0)
      $display("FAIL midrd_flush: got %b want 0", b2_v);
    else passed++;
    reset = 0;
    wait_fill(n);
    total++;
    if (n !== 16) $display("FAIL refill_len: got %0d want 16", n);
    else passed++;
    rd_both(2, 5'd3, ad, av, bd, bv, be);
    total++;
    if (ad !== 32'h0 || bd !== 32'h0 || av !== 1'b1 || bv !== 1'b1)
      $display("FAIL refill_data: got %h/%h v%b%b want 0/0 v11",
               ad, bd, av, bv);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_init_read;
    test_byte_lanes;
    test_write_collision;
    test_rdw;
    test_back_to_back;
    test_enable_stall(0);
    test_enable_stall(1);
    test_out_of_range;
    test_reset_mid_read;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
